// File: rtl/or_reduce_pipe.sv
// Registered N-input bitwise logic unit (AND/OR/XOR and inversions, or lane-0 pass)
// with an optional cross-transfer accumulator and valid/ready flow control on both sides.
module or_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [2:0]              in_mode,
    input  logic                    in_acc,
    input  logic                    in_first,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_PASS = 2'd3
    } base_op_e;

    function automatic logic [WIDTH-1:0] apply_op(
        input base_op_e         op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        unique case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    base_op_e         base_op;
    logic             invert;
    logic             pass;
    logic             xfer;
    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane_red;
    logic [WIDTH-1:0] accumulator;
    logic             acc_live;
    logic [WIDTH-1:0] acc_next;
    logic             live_next;
    logic [WIDTH-1:0] result;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign lane0    = in_data[WIDTH-1:0];
    assign pass     = (base_op == OP_PASS);

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        base_op = OP_PASS;
        invert  = 1'b0;
        unique case (in_mode)
            3'b000: base_op = OP_AND;
            3'b001: base_op = OP_OR;
            3'b010: base_op = OP_XOR;
            3'b011: begin base_op = OP_AND; invert = 1'b1; end
            3'b100: begin base_op = OP_OR;  invert = 1'b1; end
            3'b101: begin base_op = OP_XOR; invert = 1'b1; end
            default: base_op = OP_PASS;
        endcase
    end

    // NOTE: blocking assignments chain the fold within one evaluation; sequential state uses <= only.
    always_comb begin
        lane_red = lane0;
        for (int k = 1; k < N_IN; k++) begin
            lane_red = apply_op(base_op, lane_red, in_data[k*WIDTH +: WIDTH]);
        end
    end

    // The accumulator holds the non-inverted value so a mid-group mode change stays meaningful.
    always_comb begin
        acc_next  = lane_red;
        live_next = 1'b0;
        if (in_acc) begin
            live_next = 1'b1;
            if (!in_first && acc_live) begin
                acc_next = apply_op(base_op, accumulator, lane_red);
            end
        end
    end

    always_comb begin
        if (pass) begin
            result = lane0;
        end else if (invert) begin
            result = ~acc_next;
        end else begin
            result = acc_next;
        end
    end

    // NOTE: the accumulator is a plain register, so it is reset together with the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            accumulator <= '0;
            acc_live    <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= result;
            if (!pass) begin
                accumulator <= acc_next;
                acc_live    <= live_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed-vector bench for or_reduce_pipe (WIDTH=8/N_IN=4) plus randomised
// valid/ready runs of WIDTH=1/N_IN=2 and WIDTH=16/N_IN=7 against a cycle model.
module tb_or_reduce_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance: WIDTH=8, N_IN=4
    logic [31:0] in_data;
    logic [2:0]  in_mode;
    logic        in_acc, in_first, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  out_data;

    // small instance: WIDTH=1, N_IN=2
    logic [1:0]  b_in_data;
    logic [2:0]  b_in_mode;
    logic        b_in_acc, b_in_first, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0]  b_out_data;

    // wide instance: WIDTH=16, N_IN=7
    logic [111:0] c_in_data;
    logic [2:0]   c_in_mode;
    logic         c_in_acc, c_in_first, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [15:0]  c_out_data;

    or_reduce_pipe #(.WIDTH(8), .N_IN(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode), .in_acc(in_acc),
        .in_first(in_first), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

    or_reduce_pipe #(.WIDTH(1), .N_IN(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_mode(b_in_mode), .in_acc(b_in_acc),
        .in_first(b_in_first), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready));

    or_reduce_pipe #(.WIDTH(16), .N_IN(7)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_mode(c_in_mode), .in_acc(c_in_acc),
        .in_first(c_in_first), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [2:0]  mode;
        logic        acc;
        logic        first;
        logic [7:0]  exp;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] d, input logic [2:0] m,
                                input logic a, input logic f, input logic [7:0] e);
        vec_t v;
        v.data = d; v.mode = m; v.acc = a; v.first = f; v.exp = e;
        return v;
    endfunction

    // Reference model state for the randomised instances (index 0 = b, 1 = c)
    logic [15:0] m_out[2];
    logic [15:0] m_acc[2];
    logic        m_valid[2];
    logic        m_live[2];

    function automatic logic [15:0] op16(input int base, input logic [15:0] a, input logic [15:0] b);
        if (base == 0) return a & b;
        if (base == 1) return a | b;
        return a ^ b;
    endfunction

    task automatic model_step(input int id, input logic [111:0] data, input int n, input int w,
                              input logic [2:0] mode, input logic acc, input logic first,
                              input logic valid, input logic ordy);
        logic [15:0] mask, lr, nxt, lane;
        int base;
        logic inv;
        mask = (w == 16) ? 16'hFFFF : 16'((17'd1 << w) - 17'd1);
        base = (mode == 3'd0 || mode == 3'd3) ? 0 :
               (mode == 3'd1 || mode == 3'd4) ? 1 :
               (mode == 3'd2 || mode == 3'd5) ? 2 : 3;
        inv  = (mode == 3'd3 || mode == 3'd4 || mode == 3'd5);
        if (valid && (!m_valid[id] || ordy)) begin
            m_valid[id] = 1'b1;
            if (base == 3) begin
                m_out[id] = 16'(data) & mask;
            end else begin
                lr = 16'(data) & mask;
                for (int k = 1; k < n; k++) begin
                    lane = 16'(data >> (k * w)) & mask;
                    lr = op16(base, lr, lane);
                end
                if (!acc) begin
                    nxt = lr; m_live[id] = 1'b0;
                end else if (first || !m_live[id]) begin
                    nxt = lr; m_live[id] = 1'b1;
                end else begin
                    nxt = op16(base, m_acc[id], lr);
                end
                m_acc[id] = nxt;
                m_out[id] = inv ? (~nxt & mask) : nxt;
            end
        end else if (ordy) begin
            m_valid[id] = 1'b0;
        end
    endtask

    vec_t vecs[16];

    initial begin
        // 1/2: lanes 01,02,04,08 under every mode
        vecs[0]  = mk(32'h08040201, 3'b001, 1'b0, 1'b0, 8'h0F);
        vecs[1]  = mk(32'h08040201, 3'b000, 1'b0, 1'b0, 8'h00);
        vecs[2]  = mk(32'h08040201, 3'b010, 1'b0, 1'b0, 8'h0F);
        vecs[3]  = mk(32'h08040201, 3'b011, 1'b0, 1'b0, 8'hFF);
        vecs[4]  = mk(32'h08040201, 3'b100, 1'b0, 1'b0, 8'hF0);
        vecs[5]  = mk(32'h08040201, 3'b101, 1'b0, 1'b0, 8'hF0);
        vecs[6]  = mk(32'h08040201, 3'b110, 1'b0, 1'b0, 8'h01);
        vecs[7]  = mk(32'h08040201, 3'b111, 1'b1, 1'b0, 8'h01);
        // 3: XOR group, restart with in_first
        vecs[8]  = mk(32'h000000FF, 3'b010, 1'b1, 1'b1, 8'hFF);
        vecs[9]  = mk(32'h0000000F, 3'b010, 1'b1, 1'b0, 8'hF0);
        vecs[10] = mk(32'h00000001, 3'b010, 1'b1, 1'b1, 8'h01);
        // mode changes mid-group act on the non-inverted accumulator; pass leaves it alone
        vecs[11] = mk(32'h0000000F, 3'b001, 1'b1, 1'b0, 8'h0F);
        vecs[12] = mk(32'h00000030, 3'b100, 1'b1, 1'b0, 8'hC0);
        vecs[13] = mk(32'h000000AA, 3'b110, 1'b1, 1'b0, 8'hAA);
        vecs[14] = mk(32'h00000001, 3'b010, 1'b1, 1'b0, 8'h3E);
        // a non-accumulating beat ends the group: next in_first=0 beat starts fresh
        vecs[15] = mk(32'hFFFFFFFF, 3'b000, 1'b0, 1'b0, 8'hFF);

        rst = 1'b1;
        in_data = '0; in_mode = '0; in_acc = 0; in_first = 0; in_valid = 0; out_ready = 0;
        b_in_data = '0; b_in_mode = '0; b_in_acc = 0; b_in_first = 0; b_in_valid = 0; b_out_ready = 0;
        c_in_data = '0; c_in_mode = '0; c_in_acc = 0; c_in_first = 0; c_in_valid = 0; c_out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = '0; m_acc[i] = '0; m_valid[i] = 1'b0; m_live[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'h00);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset b out_valid", 32'(b_out_valid), 32'd0);
        check("reset c out_data", 32'(c_out_data), 32'h0000);

        // table-driven vectors, back-to-back beats with out_ready=1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        foreach (vecs[i]) begin
            in_data = vecs[i].data; in_mode = vecs[i].mode;
            in_acc = vecs[i].acc; in_first = vecs[i].first;
            tick();
            check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
        end
        in_data = 32'h00000011; in_mode = 3'b010; in_acc = 1'b1; in_first = 1'b0;
        tick();
        check("fresh group after acc=0", 32'(out_data), 32'h11);

        // drain with no transfer: valid drops, data holds
        in_valid = 1'b0;
        tick();
        check("drain out_valid", 32'(out_valid), 32'd0);
        check("drain out_data", 32'(out_data), 32'h11);

        // 4: backpressure with a live accumulator
        in_valid = 1'b1; in_data = 32'h0000000F; in_mode = 3'b010; in_acc = 1'b1; in_first = 1'b1;
        tick();
        check("bp first beat", 32'(out_data), 32'h0F);
        out_ready = 1'b0; in_data = 32'h000000F0; in_first = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
            tick();
            check($sformatf("bp%0d out_data", i), 32'(out_data), 32'h0F);
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp release out_data", 32'(out_data), 32'hFF);
        check("bp release out_valid", 32'(out_valid), 32'd1);
        in_data = 32'h00000001;
        tick();
        check("bp single accumulate", 32'(out_data), 32'hFE);

        // 5: reset mid-group and mid-stall
        in_data = 32'h00000055; in_first = 1'b1;
        tick();
        check("pre-reset beat", 32'(out_data), 32'h55);
        out_ready = 1'b0; in_first = 1'b0; in_data = 32'h000000AA;
        tick();
        rst = 1'b1;
        tick();
        check("stall reset out_valid", 32'(out_valid), 32'd0);
        check("stall reset out_data", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        tick();
        check("reset beats transfer", 32'(out_valid), 32'd0);
        rst = 1'b0; in_data = 32'h00000003; in_acc = 1'b1; in_first = 1'b0;
        tick();
        check("post-reset new group", 32'(out_data), 32'h03);
        check("post-reset out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();

        // 6: randomised valid/ready against the model on the other two configurations
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [127:0] r;
            r = {$urandom, $urandom, $urandom, $urandom};
            b_in_data = r[1:0];  b_in_mode = 3'($urandom_range(7));
            b_in_acc = 1'($urandom_range(1)); b_in_first = ($urandom_range(3) == 0);
            b_in_valid = ($urandom_range(9) < 7); b_out_ready = ($urandom_range(9) < 6);
            r = {$urandom, $urandom, $urandom, $urandom};
            c_in_data = r[111:0]; c_in_mode = 3'($urandom_range(7));
            c_in_acc = 1'($urandom_range(1)); c_in_first = ($urandom_range(3) == 0);
            c_in_valid = ($urandom_range(9) < 7); c_out_ready = ($urandom_range(9) < 6);
            #1;
            check("rand b in_ready", 32'(b_in_ready), 32'(!m_valid[0] || b_out_ready));
            check("rand c in_ready", 32'(c_in_ready), 32'(!m_valid[1] || c_out_ready));
            model_step(0, 112'(b_in_data), 2, 1, b_in_mode, b_in_acc, b_in_first, b_in_valid, b_out_ready);
            model_step(1, c_in_data, 7, 16, c_in_mode, c_in_acc, c_in_first, c_in_valid, c_out_ready);
            tick();
            check("rand b out_valid", 32'(b_out_valid), 32'(m_valid[0]));
            check("rand b out_data", 32'(b_out_data), 32'(m_out[0][0]));
            check("rand c out_valid", 32'(c_out_valid), 32'(m_valid[1]));
            check("rand c out_data", 32'(c_out_data), 32'(m_out[1]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
